// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares the single core memory bus between instruction fetch (IF) and data
//   access (MEM). One bus transaction is in flight at a time. The payload of
//   the granted requester is latched into the bus_* registers and held until
//   the slave answers with bus_ready (or the watchdog aborts the transfer).
//   MEM normally wins. IF is forced through after STARVE_LIMIT consecutive MEM
//   grants taken while IF was waiting. A PC redirect (if_flush) that arrives
//   while the IF fetch is on the bus lets the transfer finish but swallows its
//   ack.
//
// Ports:
//   clk, reset              core clock, synchronous active-high reset
//   if_req/if_addr          fetch request, held until if_ack or if_flush
//   if_flush                redirect: cancel/drop the current fetch
//   if_ack/if_rdata         1-cycle completion pulse and fetched word
//   dmem_req/_we/_addr/     data request and payload, held until dmem_ack
//     _wdata/_wstrb
//   dmem_ack/dmem_rdata     1-cycle completion pulse and load data
//   bus_err                 pulses with the ack of a watchdog-aborted access
//   bus_valid/_we/_addr/    bus request and latched payload
//     _wdata/_wstrb
//   bus_ready/bus_rdata     slave completion and read data
//   stall_pipl              a pipeline request is still unserviced
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int ADDR_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int BUS_TIMEOUT  = 64
) (
   input  logic                clk,
   input  logic                reset,
   // instruction fetch port
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_flush,
   output logic                if_ack,
   output logic [XLEN-1:0]     if_rdata,
   // data access port
   input  logic                dmem_req,
   input  logic                dmem_we,
   input  logic [ADDR_W-1:0]   dmem_addr,
   input  logic [XLEN-1:0]     dmem_wdata,
   input  logic [XLEN/8-1:0]   dmem_wstrb,
   output logic                dmem_ack,
   output logic [XLEN-1:0]     dmem_rdata,
   output logic                bus_err,
   // memory bus
   output logic                bus_valid,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [XLEN-1:0]     bus_wdata,
   output logic [XLEN/8-1:0]   bus_wstrb,
   input  logic                bus_ready,
   input  logic [XLEN-1:0]     bus_rdata,
   // pipeline control
   output logic                stall_pipl
);

   localparam int STRB_W   = XLEN / 8;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam int TMO_W    = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
   localparam bit TMO_EN   = (BUS_TIMEOUT > 0);

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
   // Last tmo_cnt value before an abort; with the watchdog disabled the
   // counter simply stays at zero.
   localparam logic [TMO_W-1:0]    TMO_LAST   =
      TMO_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   state_t                state_q,      state_d;
   logic                  bus_valid_q,  bus_valid_d;
   logic                  bus_we_q,     bus_we_d;
   logic [ADDR_W-1:0]     bus_addr_q,   bus_addr_d;
   logic [XLEN-1:0]       bus_wdata_q,  bus_wdata_d;
   logic [STRB_W-1:0]     bus_wstrb_q,  bus_wstrb_d;
   logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
   logic [TMO_W-1:0]      tmo_cnt_q,    tmo_cnt_d;
   logic                  drop_q,       drop_d;

   logic if_want;
   logic if_forced;
   logic busy;
   logic tmo_hit;
   logic xfer_done;
   logic if_drop;

   // ---------------------------------------------------------------------
   // Request qualification and completion detection
   // ---------------------------------------------------------------------
   assign if_want   = if_req & ~if_flush;
   assign if_forced = if_want & (starve_cnt_q == STARVE_MAX);
   assign busy      = (state_q != ST_IDLE);
   assign tmo_hit   = TMO_EN & busy & ~bus_ready & (tmo_cnt_q == TMO_LAST);
   assign xfer_done = busy & (bus_ready | tmo_hit);
   // A flush in the completing cycle itself also cancels the fetch ack.
   assign if_drop   = drop_q | if_flush;

   // ---------------------------------------------------------------------
   // Completion outputs (combinational from the bus response)
   // Acks are masked during reset so an abandoned transfer never completes.
   // ---------------------------------------------------------------------
   assign if_ack     = ~reset & xfer_done & (state_q == ST_BUSY_I) & ~if_drop;
   assign dmem_ack   = ~reset & xfer_done & (state_q == ST_BUSY_D);
   assign bus_err    = tmo_hit & (if_ack | dmem_ack);
   assign if_rdata   = (if_ack & ~tmo_hit) ? bus_rdata : '0;
   // Stores return no data, so rdata stays zero on a store ack.
   assign dmem_rdata = (dmem_ack & ~tmo_hit & ~bus_we_q) ? bus_rdata : '0;
   assign stall_pipl = (if_req & ~if_ack & ~if_flush) | (dmem_req & ~dmem_ack);

   assign bus_valid = bus_valid_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_wstrb = bus_wstrb_q;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      bus_valid_d  = bus_valid_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      bus_wstrb_d  = bus_wstrb_q;
      starve_cnt_d = starve_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      drop_d       = drop_q;

      case (state_q)
         ST_IDLE: begin
            drop_d = 1'b0;
            if (dmem_req && !if_forced) begin
               state_d     = ST_BUSY_D;
               bus_valid_d = 1'b1;
               bus_we_d    = dmem_we;
               bus_addr_d  = dmem_addr;
               bus_wdata_d = dmem_wdata;
               bus_wstrb_d = dmem_we ? dmem_wstrb : '0;
               tmo_cnt_d   = '0;
               // Count only MEM grants that actually made IF wait.
               if (if_want && (starve_cnt_q != STARVE_MAX)) begin
                  starve_cnt_d = starve_cnt_q + STARVE_W'(1);
               end
            end else if (if_want) begin
               state_d      = ST_BUSY_I;
               bus_valid_d  = 1'b1;
               bus_we_d     = 1'b0;
               bus_addr_d   = if_addr;
               bus_wdata_d  = '0;
               bus_wstrb_d  = '0;
               tmo_cnt_d    = '0;
               starve_cnt_d = '0;
            end
         end

         ST_BUSY_I, ST_BUSY_D: begin
            if (xfer_done) begin
               state_d     = ST_IDLE;
               bus_valid_d = 1'b0;
               drop_d      = 1'b0;
            end else begin
               // Reaching here implies bus_ready=0: one more waited cycle.
               if (tmo_cnt_q != TMO_LAST) begin
                  tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               end
               if ((state_q == ST_BUSY_I) && if_flush) begin
                  drop_d = 1'b1;
               end
            end
         end

         default: begin
            state_d     = ST_IDLE;
            bus_valid_d = 1'b0;
         end
      endcase

      // IF not asking at all means it is not being starved.
      if (!if_req) begin
         starve_cnt_d = '0;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         bus_valid_q  <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         bus_wstrb_q  <= '0;
         starve_cnt_q <= '0;
         tmo_cnt_q    <= '0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bus_valid_q  <= bus_valid_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         bus_wstrb_q  <= bus_wstrb_d;
         starve_cnt_q <= starve_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         drop_q       <= drop_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios for arbitration order, starvation, wait states, flush,
// watchdog abort and reset, followed by a randomized run. Every cycle is also
// compared against a transaction-level reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int XLEN         = 32;
   localparam int ADDR_W       = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int BUS_TIMEOUT  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req, if_flush, if_ack;
   logic [ADDR_W-1:0] if_addr;
   logic [XLEN-1:0]   if_rdata;
   logic              dmem_req, dmem_we, dmem_ack, bus_err;
   logic [ADDR_W-1:0] dmem_addr;
   logic [XLEN-1:0]   dmem_wdata, dmem_rdata;
   logic [3:0]        dmem_wstrb;
   logic              bus_valid, bus_we, bus_ready;
   logic [ADDR_W-1:0] bus_addr;
   logic [XLEN-1:0]   bus_wdata, bus_rdata;
   logic [3:0]        bus_wstrb;
   logic              stall_pipl;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .XLEN(XLEN), .ADDR_W(ADDR_W),
      .STARVE_LIMIT(STARVE_LIMIT), .BUS_TIMEOUT(BUS_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_ack(if_ack), .if_rdata(if_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .bus_err(bus_err),
      .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata),
      .stall_pipl(stall_pipl)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // DUT outputs sampled at the falling edge of the current cycle
   logic              s_if_ack, s_dmem_ack, s_bus_err, s_bus_valid, s_bus_we, s_stall;
   logic [XLEN-1:0]   s_if_rdata, s_dmem_rdata, s_bus_wdata;
   logic [ADDR_W-1:0] s_bus_addr;
   logic [3:0]        s_bus_wstrb;

   // Reference model: which requester owns the bus and what it asked for.
   int                m_owner  = 0;   // 0 = bus free, 1 = IF, 2 = MEM
   int                m_age    = 0;   // cycles already waited in this transfer
   bit                m_drop   = 0;   // fetch was redirected while on the bus
   int                m_starve = 0;   // MEM grants taken while IF kept waiting
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [XLEN-1:0]   m_wdata;
   logic [3:0]        m_wstrb;

   // Finish the current cycle: sample, compare with the model, advance the
   // model, then move to just after the next rising edge.
   task automatic tick();
      bit          done, tmo, dropped, ifw;
      logic        e_if_ack, e_dm_ack, e_err;
      logic [31:0] e_if_rd, e_dm_rd;
      @(negedge clk);
      s_if_ack = if_ack;     s_dmem_ack = dmem_ack;     s_bus_err = bus_err;
      s_if_rdata = if_rdata; s_dmem_rdata = dmem_rdata; s_bus_valid = bus_valid;
      s_bus_we = bus_we;     s_bus_addr = bus_addr;     s_bus_wdata = bus_wdata;
      s_bus_wstrb = bus_wstrb; s_stall = stall_pipl;

      e_if_ack = 0; e_dm_ack = 0; e_err = 0; e_if_rd = 0; e_dm_rd = 0;
      done = 0; tmo = 0; dropped = 0;
      if (m_owner != 0) begin
         tmo     = !bus_ready && (m_age == BUS_TIMEOUT - 1);
         done    = bus_ready || tmo;
         dropped = (m_owner == 1) && (m_drop || if_flush);
         if (done && !reset) begin
            if (m_owner == 2) begin
               e_dm_ack = 1;
               if (!tmo && !m_we) e_dm_rd = bus_rdata;
            end else if (!dropped) begin
               e_if_ack = 1;
               if (!tmo) e_if_rd = bus_rdata;
            end
            e_err = tmo && (e_if_ack || e_dm_ack);
         end
      end

      chk("bus_valid", s_bus_valid, (m_owner != 0));
      if (m_owner != 0) begin
         chk("bus_addr", s_bus_addr, m_addr);
         chk("bus_we", s_bus_we, m_we);
         chk("bus_wstrb", s_bus_wstrb, m_wstrb);
         if (m_we) chk("bus_wdata", s_bus_wdata, m_wdata);
      end
      chk("if_ack", s_if_ack, e_if_ack);
      chk("dmem_ack", s_dmem_ack, e_dm_ack);
      chk("bus_err", s_bus_err, e_err);
      chk("if_rdata", s_if_rdata, e_if_rd);
      chk("dmem_rdata", s_dmem_rdata, e_dm_rd);
      chk("stall_pipl", s_stall,
          (if_req && !e_if_ack && !if_flush) || (dmem_req && !e_dm_ack));

      if (reset) begin
         m_owner = 0; m_starve = 0; m_drop = 0;
      end else if (m_owner != 0) begin
         if (done) m_owner = 0;
         else begin
            m_age++;
            if (m_owner == 1 && if_flush) m_drop = 1;
         end
      end else begin
         ifw = if_req && !if_flush;
         if (dmem_req && !(ifw && m_starve == STARVE_LIMIT)) begin
            m_owner = 2; m_age = 0; m_we = dmem_we; m_addr = dmem_addr;
            m_wdata = dmem_wdata; m_wstrb = dmem_we ? dmem_wstrb : 4'b0;
            if (ifw && m_starve < STARVE_LIMIT) m_starve++;
         end else if (ifw) begin
            m_owner = 1; m_age = 0; m_drop = 0; m_we = 0; m_addr = if_addr;
            m_wstrb = 4'b0; m_starve = 0;
         end
      end
      if (!if_req) m_starve = 0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  nacks, pat, acks, ready_pct;
      bit  if_pend, dm_pend;

      reset = 1; if_req = 0; if_addr = 0; if_flush = 0;
      dmem_req = 0; dmem_we = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
      bus_ready = 0; bus_rdata = 0;
      tick();
      tick();
      chk("rst_valid", s_bus_valid, 0);
      chk("rst_addr", s_bus_addr, 0);
      chk("rst_wdata", s_bus_wdata, 0);
      chk("rst_wstrb", s_bus_wstrb, 0);
      chk("rst_we", s_bus_we, 0);
      reset = 0;
      tick();

      // Simultaneous requests, zero-wait slave
      if_req = 1; if_addr = 'h100; dmem_req = 1; dmem_we = 0; dmem_addr = 'h2000;
      tick();
      chk("t1_stall_c0", s_stall, 1);
      bus_ready = 1; bus_rdata = 'hA5A5_0001;
      tick();
      chk("t1_addr_c1", s_bus_addr, 'h2000);
      chk("t1_dack_c1", s_dmem_ack, 1);
      chk("t1_drdata_c1", s_dmem_rdata, 'hA5A5_0001);
      chk("t1_stall_c1", s_stall, 1);
      dmem_req = 0; bus_rdata = 'h1111_1111;
      tick();
      chk("t1_idle_c2", s_bus_valid, 0);
      chk("t1_stall_c2", s_stall, 1);
      bus_rdata = 'hC0DE_0100;
      tick();
      chk("t1_valid_c3", s_bus_valid, 1);
      chk("t1_addr_c3", s_bus_addr, 'h100);
      chk("t1_iack_c3", s_if_ack, 1);
      chk("t1_irdata_c3", s_if_rdata, 'hC0DE_0100);
      if_req = 0; bus_ready = 0;
      tick();

      // Starvation: continuous MEM traffic with IF waiting
      bus_ready = 1; if_req = 1; if_addr = 'h140;
      dmem_req = 1; dmem_we = 0; dmem_addr = 'h3000;
      nacks = 0; pat = 0;
      for (int c = 0; c < 40 && nacks < 6; c++) begin
         tick();
         if (s_dmem_ack) begin pat = pat << 1; nacks++; dmem_addr = dmem_addr + 4; end
         if (s_if_ack)   begin pat = (pat << 1) | 1; nacks++; if_req = 0; end
      end
      chk("t2_nacks", nacks, 6);
      chk("t2_order_MMMMIM", pat, 'b000010);
      dmem_req = 0; bus_ready = 0;
      tick();

      // Store with three wait states
      dmem_req = 1; dmem_we = 1; dmem_addr = 'h4000; dmem_wdata = 'hDEAD_BEEF;
      dmem_wstrb = 4'b0011; bus_rdata = 'h1234_5678;
      tick();
      acks = 0;
      for (int c = 1; c <= 5; c++) begin
         bus_ready = (c == 4);
         tick();
         if (c <= 4) begin
            chk("t3_valid", s_bus_valid, 1);
            chk("t3_addr", s_bus_addr, 'h4000);
            chk("t3_we", s_bus_we, 1);
            chk("t3_wdata", s_bus_wdata, 'hDEAD_BEEF);
            chk("t3_wstrb", s_bus_wstrb, 4'b0011);
         end
         if (c == 4) chk("t3_rdata", s_dmem_rdata, 0);
         if (s_dmem_ack) begin acks++; dmem_req = 0; end
      end
      chk("t3_single_ack", acks, 1);
      dmem_we = 0; bus_ready = 0;

      // Flush during BUSY_I
      if_req = 1; if_addr = 'h400;
      tick();
      if_flush = 1;
      tick();
      chk("t4_busy", s_bus_valid, 1);
      if_flush = 0; if_req = 0;
      tick();
      bus_ready = 1; bus_rdata = 'hBAD0_0400;
      tick();
      chk("t4_no_iack", s_if_ack, 0);
      chk("t4_no_err", s_bus_err, 0);
      bus_ready = 0; if_req = 1; if_addr = 'h500;
      tick();
      chk("t4_idle", s_bus_valid, 0);
      bus_ready = 1; bus_rdata = 'h600D_0500;
      tick();
      chk("t4_regrant_addr", s_bus_addr, 'h500);
      chk("t4_regrant_ack", s_if_ack, 1);
      if_req = 0; bus_ready = 0;
      tick();

      // Watchdog abort on a load with a dead slave
      dmem_req = 1; dmem_we = 0; dmem_addr = 'h6000; bus_rdata = 'hFFFF_FFFF;
      tick();
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c < 8) chk("t5_no_early_ack", s_dmem_ack, 0);
         if (c == 8) begin
            chk("t5_ack", s_dmem_ack, 1);
            chk("t5_err", s_bus_err, 1);
            chk("t5_rdata", s_dmem_rdata, 0);
         end
         if (c == 9) chk("t5_released", s_bus_valid, 0);
         if (s_dmem_ack) dmem_req = 0;
      end

      // Reset in the middle of BUSY_D
      dmem_req = 1; dmem_addr = 'h7000;
      tick();
      tick();
      reset = 1; bus_ready = 1;
      tick();
      chk("t6_no_ack_in_rst", s_dmem_ack, 0);
      reset = 0; bus_ready = 0;
      tick();
      chk("t6_valid_after", s_bus_valid, 0);
      chk("t6_acks_after", s_dmem_ack | s_if_ack, 0);
      tick();
      chk("t6_regrant_valid", s_bus_valid, 1);
      chk("t6_regrant_addr", s_bus_addr, 'h7000);
      bus_ready = 1;
      tick();
      chk("t6_ack", s_dmem_ack, 1);
      dmem_req = 0; bus_ready = 0;
      tick();

      // Randomized traffic obeying the request hold rules
      if_pend = 0; dm_pend = 0;
      for (int c = 0; c < 4000; c++) begin
         ready_pct = ((c / 500) % 2 == 1) ? 8 : 65;
         if (if_pend && (s_if_ack || if_flush)) if_pend = 0;
         if (dm_pend && s_dmem_ack) dm_pend = 0;
         if (!if_pend && $urandom_range(0, 99) < 60) begin
            if_pend = 1; if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!dm_pend && $urandom_range(0, 99) < 50) begin
            dm_pend = 1; dmem_we = 1'($urandom_range(0, 1)); dmem_addr = $urandom;
            dmem_wdata = $urandom; dmem_wstrb = 4'($urandom_range(0, 15));
         end
         if_req    = if_pend;
         dmem_req  = dm_pend;
         if_flush  = ($urandom_range(0, 99) < 7);
         bus_ready = ($urandom_range(0, 99) < ready_pct);
         bus_rdata = $urandom;
         reset     = ($urandom_range(0, 999) < 4);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
